dual_port_ram_host_ctrl: RTL

//  Single-clock command-driven host for the 8x16 dual-port RAM. It drives the RAM write port
//  (we/en=0/addr_w/data_w), read port (en/we=0/addr_r) and rst, and captures data_r.

---
 rtl/dual_port_ram_host_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dual_port_ram_host_ctrl.sv
// Command-driven host controller for an 8x16 dual-port RAM.
// Sequences write, read and clear bursts over valid/ready streams.
module dual_port_ram_host_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              ram_we,
  output logic              ram_en,
  output logic              ram_rst,
  output logic [ADDR_W-1:0] ram_addr_w,
  output logic [ADDR_W-1:0] ram_addr_r,
  output logic [DATA_W-1:0] ram_data_w,
  input  logic [DATA_W-1:0] ram_data_r
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_CAP,
    S_RD_HOLD,
    S_CLR,
    S_CLR_WAIT
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [ADDR_W-1:0]   r_beats_left;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_done;
  logic                r_err;
  logic                r_ram_we;
  logic                r_ram_en;
  logic                r_ram_rst;
  logic [ADDR_W-1:0]   r_ram_addr_w;
  logic [ADDR_W-1:0]   r_ram_addr_r;
  logic [DATA_W-1:0]   r_ram_data_w;

  logic                w_last;
  logic [ADDR_W-1:0]   w_next_addr;

  assign w_last      = (r_beats_left == '0);
  assign w_next_addr = r_cur_addr + ADDR_W'(1);

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign wr_ready   = (r_state == S_WR);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign done       = r_done;
  assign err        = r_err;
  assign ram_we     = r_ram_we;
  assign ram_en     = r_ram_en;
  assign ram_rst    = r_ram_rst;
  assign ram_addr_w = r_ram_addr_w;
  assign ram_addr_r = r_ram_addr_r;
  assign ram_data_w = r_ram_data_w;

  // Burst sequencer; every RAM strobe and status pulse is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cur_addr   <= '0;
      r_beats_left <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_en     <= 1'b0;
      r_ram_rst    <= 1'b0;
      r_ram_addr_w <= '0;
      r_ram_addr_r <= '0;
      r_ram_data_w <= '0;
    end else begin
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_ram_we  <= 1'b0;
      r_ram_en  <= 1'b0;
      r_ram_rst <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_cur_addr   <= cmd_addr;
            r_beats_left <= cmd_len;
            unique case (1'b1)
              (cmd_op == 2'b00): r_state <= S_WR;
              (cmd_op == 2'b01): r_state <= S_RD_ISSUE;
              (cmd_op == 2'b10): r_state <= S_CLR;
              default:           r_err   <= 1'b1;
            endcase
          end
        end
        S_WR: begin
          if (wr_valid) begin
            r_ram_we     <= 1'b1;
            r_ram_addr_w <= r_cur_addr;
            r_ram_data_w <= wr_data;
            r_cur_addr   <= w_next_addr;
            if (w_last) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_beats_left <= r_beats_left - ADDR_W'(1);
            end
          end
        end
        S_RD_ISSUE: begin
          r_ram_en     <= 1'b1;
          r_ram_addr_r <= r_cur_addr;
          r_state      <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          r_state <= S_RD_CAP;
        end
        S_RD_CAP: begin
          r_rsp_data  <= ram_data_r;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RD_HOLD;
        end
        S_RD_HOLD: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (w_last) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_cur_addr   <= w_next_addr;
              r_beats_left <= r_beats_left - ADDR_W'(1);
              r_state      <= S_RD_ISSUE;
            end
          end
        end
        S_CLR: begin
          r_ram_rst <= 1'b1;
          r_state   <= S_CLR_WAIT;
        end
        S_CLR_WAIT: begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
